// File: rtl/ethernet_rx_framer.sv
// ethernet_rx_framer: MII nibble stream to payload bytes with FCS strip and frame status; define ETHERNET_RX_CRC_EN to build the CRC-32 check
module ethernet_rx_framer #(
  parameter int MIN_FRAME_BYTES      = 64,
  parameter int MAX_FRAME_BYTES      = 1518,
  parameter int PREAMBLE_MIN_NIBBLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nibble_ready,
  input  logic [3:0]  nibble,
  input  logic        last_nibble,
  output logic        data_valid,
  output logic [7:0]  data,
  output logic        data_first,
  output logic        frame_end,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_length,
  output logic        err_align,
  output logic [10:0] frame_length
);
  localparam logic [10:0] MIN_B   = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_B   = 11'(MAX_FRAME_BYTES);
  localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN_NIBBLES);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;
  state_t state, next_state;
  logic [3:0] pre_cnt, lo_nib;
  logic half, byte_done, emit, first, fe, fin_half, len_bad, crc_bad;
  logic [10:0] cnt, cnt_inc, fin_cnt;
  logic [31:0] dl;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (nibble_ready && nibble == 4'h5) next_state = PREAMBLE;
      PREAMBLE: if (last_nibble) next_state = IDLE;
                else if (nibble_ready)
                  next_state = nibble == 4'h5 ? PREAMBLE :
                               (nibble == 4'hD && pre_cnt >= PRE_MIN) ? DATA : DISCARD;
      default:  if (last_nibble) next_state = IDLE;
    endcase
  end
  always_comb begin
    byte_done = state == DATA && nibble_ready && half;
    cnt_inc   = cnt == 11'h7FF ? cnt : cnt + 11'd1;
    emit      = byte_done && cnt >= 11'd4 && cnt < MAX_B;
    first     = byte_done && cnt == 11'd4;
    fe        = state == DATA && last_nibble;
    fin_half  = half ^ nibble_ready;
    fin_cnt   = byte_done ? cnt_inc : cnt;
    len_bad   = fin_cnt < MIN_B || fin_cnt > MAX_B;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pre_cnt <= '0;
      lo_nib  <= '0;
      half    <= 1'b0;
      cnt     <= '0;
      dl      <= '0;
    end else begin
      if (nibble_ready && state == IDLE) pre_cnt <= 4'd1;
      else if (nibble_ready && state == PREAMBLE && pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
      if (state == PREAMBLE) begin
        cnt  <= '0;
        half <= 1'b0;
      end else if (state == DATA && nibble_ready) begin
        half <= ~half;
        if (!half) lo_nib <= nibble;
        else begin
          cnt <= cnt_inc;
          dl  <= {dl[23:0], nibble, lo_nib};
        end
      end
    end
`ifdef ETHERNET_RX_CRC_EN
  logic [31:0] crc, crc_upd;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return c;
  endfunction
  always_comb crc_upd = crc_byte(crc, {nibble, lo_nib});
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) crc <= '1;
    else if (state == PREAMBLE) crc <= '1;
    else if (byte_done) crc <= crc_upd;
  always_comb crc_bad = (byte_done ? crc_upd : crc) != 32'hDEBB20E3;
`else
  always_comb crc_bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_valid   <= 1'b0;
      data         <= '0;
      data_first   <= 1'b0;
      frame_end    <= 1'b0;
      frame_ok     <= 1'b0;
      err_crc      <= 1'b0;
      err_length   <= 1'b0;
      err_align    <= 1'b0;
      frame_length <= '0;
    end else begin
      data_valid   <= emit;
      data_first   <= first;
      if (emit) data <= dl[31:24];
      frame_end    <= fe;
      err_align    <= fe && fin_half;
      err_length   <= fe && len_bad;
      err_crc      <= fe && crc_bad;
      frame_ok     <= fe && !fin_half && !len_bad && !crc_bad;
      frame_length <= !fe ? '0 : fin_cnt < 11'd4 ? '0 : fin_cnt - 11'd4;
    end
endmodule

// File: tb/tb_ethernet_rx_framer.sv
// tb_ethernet_rx_framer: directed bench for ethernet_rx_framer
module tb_ethernet_rx_framer;
  logic clk = 0, reset_n = 0, nibble_ready = 0, last_nibble = 0;
  logic [3:0] nibble = '0;
  logic data_valid, data_first, frame_end, frame_ok, err_crc, err_length, err_align;
  logic [7:0] data;
  logic [10:0] frame_length;
  int tests = 0, fails = 0, dv_cnt = 0, fe_cnt = 0;
  logic [7:0] frm[$];
  bit crc_en;

  ethernet_rx_framer dut (
    .clk(clk), .reset_n(reset_n), .nibble_ready(nibble_ready), .nibble(nibble),
    .last_nibble(last_nibble), .data_valid(data_valid), .data(data), .data_first(data_first),
    .frame_end(frame_end), .frame_ok(frame_ok), .err_crc(err_crc), .err_length(err_length),
    .err_align(err_align), .frame_length(frame_length)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (frame_end) fe_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction

  task automatic build(input int n, input bit flip);
    logic [31:0] c;
    int p;
    frm.delete();
    c = '1;
    p = n < 5 ? n : n - 4;
    for (int i = 0; i < p; i++) begin
      frm.push_back(8'(i * 37 + 11));
      c = crc_step(c, frm[i]);
    end
    if (n >= 5) for (int j = 0; j < 4; j++) frm.push_back(8'((~c) >> (8 * j)));
    if (flip) frm[n-1] = frm[n-1] ^ 8'h01;
  endtask

  task automatic nib(input logic [3:0] v);
    @(negedge clk) begin nibble_ready = 1; nibble = v; end
    @(negedge clk) nibble_ready = 0;
  endtask

  task automatic send(input int pre, input bit extra, input bit exp_data, input int abort,
                      input bit exp_fe, input bit e_ok, input bit e_crc, input bit e_len,
                      input bit e_al, input int e_flen);
    int base_dv, base_fe, exp_n;
    base_dv = dv_cnt;
    base_fe = fe_cnt;
    exp_n = 0;
    repeat (pre) nib(4'h5);
    nib(4'hD);
    foreach (frm[k]) begin
      bit e;
      nib(frm[k][3:0]);
      nib(frm[k][7:4]);
      e = exp_data && k >= 4 && k < 1518;
      chk("data_valid", data_valid, e);
      if (e) begin
        chk("data", data, frm[k-4]);
        chk("data_first", data_first, k == 4);
        exp_n++;
      end
      if (k + 1 == abort) begin
        #2 reset_n = 0;
        #1 chk("reset_midframe_outputs", {data_valid, data, data_first, frame_end, frame_ok,
               err_crc, err_length, err_align, frame_length}, 0);
        @(negedge clk) reset_n = 1;
        repeat (10) @(negedge clk);
        chk("abort_dv_count", dv_cnt - base_dv, exp_n);
        chk("abort_no_frame_end", fe_cnt - base_fe, 0);
        return;
      end
    end
    if (extra) nib(4'h3);
    @(negedge clk) last_nibble = 1;
    @(negedge clk) last_nibble = 0;
    chk("frame_end", frame_end, exp_fe);
    if (exp_fe) begin
      chk("frame_ok", frame_ok, e_ok);
      chk("err_crc", err_crc, e_crc);
      chk("err_length", err_length, e_len);
      chk("err_align", err_align, e_al);
      chk("frame_length", frame_length, e_flen);
    end
    @(negedge clk) chk("frame_end_one_cycle", frame_end, 0);
    repeat (4) @(negedge clk);
    chk("dv_count", dv_cnt - base_dv, exp_n);
    chk("fe_count", fe_cnt - base_fe, exp_fe);
  endtask

  initial begin
`ifdef ETHERNET_RX_CRC_EN
    crc_en = 1;
`else
    crc_en = 0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_valid, data, data_first, frame_end, frame_ok, err_crc,
        err_length, err_align, frame_length}, 0);
    reset_n = 1;
    @(negedge clk);
    chk("post_reset_outputs", {data_valid, data, data_first, frame_end, frame_ok, err_crc,
        err_length, err_align, frame_length}, 0);
    build(64, 0);   send(15, 0, 1, -1, 1, 1, 0, 0, 0, 60);
    build(64, 1);   send(15, 0, 1, -1, 1, !crc_en, crc_en, 0, 0, 60);
    build(64, 0);   send(15, 1, 1, -1, 1, 0, 0, 0, 1, 60);
    build(1519, 0); send(15, 0, 1, -1, 1, 0, 0, 1, 0, 1515);
    build(3, 0);    send(15, 0, 1, -1, 1, 0, crc_en, 1, 0, 0);
    build(64, 0);   send(6, 0, 0, -1, 0, 0, 0, 0, 0, 0);
    send(8, 0, 1, -1, 1, 1, 0, 0, 0, 60);
    send(15, 0, 1, 20, 0, 0, 0, 0, 0, 0);
    send(15, 0, 1, -1, 1, 1, 0, 0, 0, 60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
